// File: rtl/pe_bus_arbiter.sv
// Round-robin shared-bus arbiter bridging NUM_PE processing elements onto one global memory port.
// Optional gm_ready watchdog with bus_error output is enabled by defining ARB_TIMEOUT_EN.
module pe_bus_arbiter #(
    parameter int unsigned NUM_PE  = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PE-1:0]          bus_request,
    input  logic [NUM_PE-1:0]          mem_read,
    input  logic [NUM_PE-1:0]          mem_write,
    input  logic [NUM_PE*ADDR_W-1:0]   mem_address,
    input  logic [NUM_PE*DATA_W-1:0]   data_Store,
    output logic [NUM_PE-1:0]          grant,
    output logic [NUM_PE-1:0]          mem_ackBus,
    output logic [DATA_W-1:0]          memData,
    output logic                       gm_req,
    output logic                       gm_we,
    output logic [ADDR_W-1:0]          gm_addr,
    output logic [DATA_W-1:0]          gm_wdata,
`ifdef ARB_TIMEOUT_EN
    output logic                       bus_error,
`endif
    input  logic                       gm_ready,
    input  logic [DATA_W-1:0]          gm_rdata,
    output logic                       busy
);

    localparam int unsigned IDX_W = $clog2(NUM_PE);

    typedef enum logic [1:0] {IDLE, GRANT, ACCESS, ACK} state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]   sel, sel_d;
    logic [IDX_W-1:0]   pick;
    logic               pick_vld;
    logic [NUM_PE-1:0]  grant_d, ack_d;
    logic [DATA_W-1:0]  mem_data_d, gm_wdata_d;
    logic [ADDR_W-1:0]  gm_addr_d;
    logic               gm_req_d, gm_we_d, busy_d;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]      timer, timer_d;
    logic               bus_error_d;
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic [31:0]        unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    // (v + k) mod NUM_PE for v, k < NUM_PE
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] v, input int unsigned k);
        int unsigned s;
        s = 32'(v) + k;
        if (s >= NUM_PE) s = s - NUM_PE;
        return IDX_W'(s);
    endfunction

    // First requester at or after rr_ptr
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned k = 0; k < NUM_PE; k++) begin
            if (!pick_vld && bus_request[wrap_add(rr_ptr, k)]) begin
                pick     = wrap_add(rr_ptr, k);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        sel_d      = sel;
        grant_d    = grant;
        ack_d      = '0;
        mem_data_d = memData;
        gm_req_d   = gm_req;
        gm_we_d    = gm_we;
        gm_addr_d  = gm_addr;
        gm_wdata_d = gm_wdata;
`ifdef ARB_TIMEOUT_EN
        timer_d     = timer;
        bus_error_d = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    sel_d   = pick;
                    grant_d = NUM_PE'(1) << pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus_request[sel] && (mem_read[sel] || mem_write[sel])) begin
                    gm_we_d    = mem_write[sel];
                    gm_addr_d  = mem_address[ADDR_W*sel +: ADDR_W];
                    gm_wdata_d = data_Store[DATA_W*sel +: DATA_W];
                    gm_req_d   = 1'b1;
                    state_d    = ACCESS;
`ifdef ARB_TIMEOUT_EN
                    timer_d    = '0;
`endif
                end else begin
                    grant_d  = '0;
                    rr_ptr_d = wrap_add(sel, 1);
                    state_d  = IDLE;
                end
            end
            ACCESS: begin
                if (gm_ready) begin
                    if (!gm_we) mem_data_d = gm_rdata;
                    gm_req_d = 1'b0;
                    ack_d    = grant;
                    state_d  = ACK;
                end
`ifdef ARB_TIMEOUT_EN
                else if (timer == TW'(TIMEOUT - 1)) begin
                    mem_data_d  = DATA_W'(32'hDEADBEEF);
                    gm_req_d    = 1'b0;
                    ack_d       = grant;
                    bus_error_d = 1'b1;
                    state_d     = ACK;
                end else begin
                    timer_d = timer + TW'(1);
                end
`endif
            end
            ACK: begin
                grant_d  = '0;
                rr_ptr_d = wrap_add(sel, 1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            sel        <= '0;
            grant      <= '0;
            mem_ackBus <= '0;
            memData    <= '0;
            gm_req     <= 1'b0;
            gm_we      <= 1'b0;
            gm_addr    <= '0;
            gm_wdata   <= '0;
            busy       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            timer      <= '0;
            bus_error  <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            rr_ptr     <= rr_ptr_d;
            sel        <= sel_d;
            grant      <= grant_d;
            mem_ackBus <= ack_d;
            memData    <= mem_data_d;
            gm_req     <= gm_req_d;
            gm_we      <= gm_we_d;
            gm_addr    <= gm_addr_d;
            gm_wdata   <= gm_wdata_d;
            busy       <= busy_d;
`ifdef ARB_TIMEOUT_EN
            timer      <= timer_d;
            bus_error  <= bus_error_d;
`endif
        end
    end

endmodule

// File: doc/pe_bus_arbiter.md
Name: pe_bus_arbiter

Overview:
Shared-bus arbiter and global-memory bridge directly downstream of the PE bus interfaces. Collects bus_request from NUM_PE processing elements and grants one PE at a time, round-robin. Forwards the granted PE's memory read/write to the global memory port. Returns read data and a one-cycle mem_ack to that PE.

Parameters:
NUM_PE, 4, number of requesting PEs (2..16)
ADDR_W, 32, global memory address width
DATA_W, 32, data width
TIMEOUT, 15, max cycles waiting on gm_ready (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
bus_request  in  NUM_PE  per-PE bus request
mem_read  in  NUM_PE  per-PE read strobe
mem_write  in  NUM_PE  per-PE write strobe
mem_address  in  NUM_PE*ADDR_W  flattened; PE i at [ADDR_W*i +: ADDR_W]
data_Store  in  NUM_PE*DATA_W  flattened per-PE write data
grant  out  NUM_PE  one-hot grant
mem_ackBus  out  NUM_PE  one-cycle completion pulse to granted PE
memData  out  DATA_W  read data, broadcast, valid with mem_ackBus
gm_req  out  1  global memory request
gm_we  out  1  1=write, 0=read
gm_addr  out  ADDR_W  global memory address
gm_wdata  out  DATA_W  global memory write data
gm_ready  in  1  global memory done; read data valid this cycle
gm_rdata  in  DATA_W  global memory read data
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE, rr_ptr=0, grant=0, mem_ackBus=0, memData=0, gm_req=0, gm_we=0, gm_addr=0, gm_wdata=0, busy=0. Reset mid-transaction drops the transaction; no ack is issued. Global memory tolerates an abandoned gm_req.
- FSM states: IDLE, GRANT, ACCESS, ACK.
- IDLE: when any bus_request is set, select the first requester at or after rr_ptr, wrapping modulo NUM_PE. Register grant[i]=1 and go to GRANT.
- GRANT (1 cycle): sample mem_read[i], mem_write[i], the address slice and the data slice.
  - Write if mem_write[i]=1. If both read and write are set, the transaction is a write.
  - Read if only mem_read[i]=1.
  - On a write or read: load gm_addr/gm_wdata/gm_we, set gm_req=1, go to ACCESS.
  - If neither strobe is set, or bus_request[i]=0: clear grant, set rr_ptr=i+1, go to IDLE, no ack.
- ACCESS: hold gm_req, gm_we, gm_addr and gm_wdata stable until gm_ready=1. On gm_ready:
  - memData<=gm_rdata for reads; memData unchanged for writes.
  - gm_req<=0, go to ACK.
  - Requester deasserting bus_request during ACCESS does not abort the transaction.
- ACK (1 cycle): mem_ackBus[i]=1 while grant[i] stays high. Then grant<=0, rr_ptr<=(i+1) mod NUM_PE, go to IDLE.
- gm_ready outside ACCESS is ignored.
- grant is always one-hot or zero. mem_ackBus is a subset of grant.
- Latency with gm_ready high at the first gm_req cycle:
  - request sampled edge 0 -> grant edge 1 -> gm_req edge 2 -> ACK edge 3 -> IDLE edge 4.
  - Grant held 3 cycles; at least 1 IDLE cycle between consecutive grants.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: adds output port bus_error (1 bit, reset 0) and a cycle counter cleared on entry to ACCESS. If the counter reaches TIMEOUT with gm_ready still 0: gm_req<=0, memData<=32'hDEADBEEF, go to ACK, bus_error pulses 1 cycle coincident with mem_ackBus.
- Not defined: no bus_error port, no counter; ACCESS waits indefinitely.

Test Plan:
1. PE2 read, addr 0x100, gm_ready one cycle after gm_req, gm_rdata=0x87654321 -> grant=4'b0100 for 3 cycles, gm_we=0, gm_addr=0x100, mem_ackBus=4'b0100 one cycle with memData=0x87654321.
2. PE0 write, addr 0x02BB81A3, data 0x11111111 -> gm_req=1, gm_we=1, gm_addr=0x02BB81A3, gm_wdata=0x11111111; single ack to PE0; memData unchanged.
3. All four PEs request continuously, gm_ready tied 1 -> grants in order 0,1,2,3,0; each grant 3 cycles; 1 idle cycle between grants.
4. gm_ready delayed 6 cycles -> gm_req and gm_addr stable for all 6 cycles; exactly one mem_ackBus pulse; PE deasserting request mid-ACCESS still acked.
5. Reset asserted during ACCESS for PE3 -> next cycle all outputs 0, no ack to PE3; PE0 and PE3 then request together -> PE0 granted first.
6. ARB_TIMEOUT_EN, TIMEOUT=15, gm_ready held 0 -> ack after 15 ACCESS cycles, memData=0xDEADBEEF, bus_error=1 for 1 cycle; without macro, no ack ever.
